// File: rtl/lsu_unit_if.sv
// lsu_unit_if: data-memory req/gnt/rvalid bus between the load/store unit and memory
interface lsu_unit_if #(parameter int XLEN = 32);
  logic req;
  logic we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN/8-1:0] wstrb;
  logic gnt;
  logic rvalid;
  logic [XLEN-1:0] rdata;
  modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_unit.sv
// lsu_unit: execute-stage load/store unit driving one req/gnt/rvalid memory transaction per instruction
module lsu_unit #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_valid_i,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            flush_i,
  lsu_unit_if.master      mem,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            err_o,
  output logic [1:0]      err_cause_o,
  output logic [XLEN-1:0] err_addr_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  state_t state;
  logic start, legal, misaligned, ok, flushed;
  logic [1:0] off;
  logic [2:0] f3;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [31:0] rext, wdata_n;
  logic [3:0] wstrb_n;
  always_comb begin
    start = lsu_valid_i & (is_load_i | is_store_i) & ~flush_i;
    legal = funct3_i[1:0] != 2'b11 && (is_load_i ? !(funct3_i[2] && funct3_i[1]) : !funct3_i[2]);
    misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) || (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    ok = legal & ~misaligned;
    stall_o = (state == IDLE && start && ok) || state == REQ || state == RSP;
    wdata_n = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} : funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    wstrb_n = funct3_i[1:0] == 2'b00 ? 4'b0001 << addr_i[1:0] : funct3_i[1:0] == 2'b01 ? 4'b0011 << addr_i[1:0] : 4'b1111;
    rbyte = mem.rdata[{off, 3'b000} +: 8];
    rhalf = mem.rdata[{off[1], 4'b0000} +: 16];
    rext = f3[1:0] == 2'b00 ? {{24{~f3[2] & rbyte[7]}}, rbyte}
         : f3[1:0] == 2'b01 ? {{16{~f3[2] & rhalf[15]}}, rhalf} : mem.rdata;
  end
  // A flush that lands after the grant lets the bus finish but suppresses done_o
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mem.req <= 1'b0;
      mem.we <= 1'b0;
      mem.addr <= '0;
      mem.wdata <= '0;
      mem.wstrb <= '0;
      done_o <= 1'b0;
      load_data_o <= '0;
      err_o <= 1'b0;
      err_cause_o <= 2'b00;
      err_addr_o <= '0;
      off <= 2'b00;
      f3 <= 3'b000;
      flushed <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE:
          if (start && ok) begin
            mem.req <= 1'b1;
            mem.we <= ~is_load_i;
            mem.addr <= {addr_i[31:2], 2'b00};
            mem.wdata <= is_load_i ? '0 : wdata_n;
            mem.wstrb <= is_load_i ? 4'b0000 : wstrb_n;
            off <= addr_i[1:0];
            f3 <= funct3_i;
            flushed <= 1'b0;
            state <= REQ;
          end else if (start) begin
            err_o <= 1'b1;
            err_cause_o <= !legal ? 2'b11 : is_load_i ? 2'b01 : 2'b10;
            err_addr_o <= addr_i;
          end
        REQ:
          if (mem.gnt) begin
            mem.req <= 1'b0;
            if (mem.we) begin
              done_o <= ~flush_i;
              load_data_o <= '0;
              state <= flush_i ? IDLE : DONE;
            end else begin
              flushed <= flush_i;
              state <= RSP;
            end
          end else if (flush_i) begin
            mem.req <= 1'b0;
            state <= IDLE;
          end
        RSP: begin
          flushed <= flushed | flush_i;
          if (mem.rvalid) begin
            load_data_o <= rext;
            done_o <= ~(flushed | flush_i);
            state <= (flushed | flush_i) ? IDLE : DONE;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: randomized scoreboard bench for lsu_unit against a byte-addressed memory model
module tb_lsu_unit;
  logic clk = 0, rst_n = 1;
  logic lsu_valid_i = 0, is_load_i = 0, is_store_i = 0, flush_i = 0;
  logic [2:0] funct3_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0;
  logic stall_o, done_o, err_o;
  logic [31:0] load_data_o, err_addr_o;
  logic [1:0] err_cause_o;
  lsu_unit_if mem();
  lsu_unit dut(.clk(clk), .rst_n(rst_n), .lsu_valid_i(lsu_valid_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .mem(mem), .stall_o(stall_o), .done_o(done_o), .load_data_o(load_data_o),
    .err_o(err_o), .err_cause_o(err_cause_o), .err_addr_o(err_addr_o));
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb;} bus_t;
  typedef struct packed {logic [1:0] cause; logic [31:0] addr;} err_t;
  bus_t exp_bus[$];
  err_t exp_err[$];
  logic [31:0] exp_done[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, issue_cyc = 0, last_done_cyc = -1, last_gnt_cyc = -1, done_cnt = 0;
  logic [31:0] last_load = 0, last_eaddr = 0;
  logic [1:0] last_cause = 0;
  logic [7:0] ref_mem [int];
  logic [31:0] bus_mem [int];
  bit gnt_off = 0, pend = 0;
  int gdelay = -1, rmin = 0, rmax = 2, rcnt = 0, wcnt = 0;
  logic [31:0] paddr = 0;
  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic miss(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event with nothing expected", name);
  endtask
  function automatic logic [31:0] init_word(int w);
    return 32'(w) * 32'h9E3779B1 ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] rd_word(int i);
    return bus_mem.exists(i) ? bus_mem[i] : init_word(i);
  endfunction
  function automatic logic [7:0] ref_byte(int a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a / 4);
    return w[8*(a%4) +: 8];
  endfunction
  // memory slave: applies strobed writes, answers loads after a programmable delay
  initial begin
    mem.gnt = 0;
    mem.rvalid = 0;
    mem.rdata = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (mem.req && mem.gnt) begin
        if (mem.we) begin
          logic [31:0] w;
          w = rd_word(int'(mem.addr >> 2));
          for (int i = 0; i < 4; i++) if (mem.wstrb[i]) w[8*i +: 8] = mem.wdata[8*i +: 8];
          bus_mem[int'(mem.addr >> 2)] = w;
        end else begin
          pend = 1;
          paddr = mem.addr;
          rcnt = int'($urandom_range(rmax, rmin));
        end
        wcnt = 0;
      end else wcnt = mem.req ? wcnt + 1 : 0;
      #1;
      mem.rvalid = 0;
      mem.rdata = $urandom;
      if (pend) begin
        if (rcnt == 0) begin
          mem.rvalid = 1;
          mem.rdata = rd_word(int'(paddr >> 2));
          pend = 0;
        end else rcnt--;
      end
      mem.gnt = mem.req && !pend && !gnt_off && (gdelay < 0 ? $urandom_range(2, 0) == 0 : wcnt >= gdelay);
    end
  end
  logic p_req = 0, p_gnt = 0;
  bus_t p_bus = '0;
  always @(negedge clk) begin
    bus_t cur, e;
    err_t ee;
    cur = {mem.addr, mem.we, mem.wdata, mem.wstrb};
    if (rst_n) begin
      if (p_req && !p_gnt && mem.req) chk("bus_hold", 72'(cur), 72'(p_bus));
      if (mem.req && mem.gnt) begin
        last_gnt_cyc = cyc;
        if (exp_bus.size() == 0) miss("bus_grant");
        else begin
          e = exp_bus.pop_front();
          if (!e.we) begin
            e.wdata = 0;
            cur.wdata = 0;
          end
          chk("bus_fields", 72'(cur), 72'(e));
        end
      end
      if (done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
        last_load = load_data_o;
        if (exp_done.size() == 0) miss("done");
        else chk("load_data", 72'(load_data_o), 72'(exp_done.pop_front()));
      end
      if (err_o) begin
        last_cause = err_cause_o;
        last_eaddr = err_addr_o;
        if (exp_err.size() == 0) miss("err");
        else begin
          ee = exp_err.pop_front();
          chk("err", 72'({err_cause_o, err_addr_o}), 72'(ee));
        end
      end
    end
    p_req = rst_n && mem.req;
    p_gnt = mem.gnt;
    p_bus = {mem.addr, mem.we, mem.wdata, mem.wstrb};
  end
  // reference model: byte memory, access size and sign rules; then drive and wait for completion
  task automatic issue(bit v, bit ld, bit st, bit fl, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    bit start, legal, ok;
    int sz;
    bus_t b;
    err_t e;
    logic [31:0] val;
    start = v && (ld || st) && !fl;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    sz = 1 << f3[1:0];
    ok = start && legal && (int'(a % 32'(sz)) == 0);
    if (start && !ok) begin
      e.cause = !legal ? 2'b11 : ld ? 2'b01 : 2'b10;
      e.addr = a;
      exp_err.push_back(e);
    end
    if (ok) begin
      b = '0;
      b.addr = a & ~32'd3;
      b.we = !ld;
      val = 0;
      for (int i = 0; i < sz; i++)
        if (ld) val |= 32'(ref_byte(int'(a) + i)) << (8*i);
        else begin
          ref_mem[int'(a) + i] = d[8*i +: 8];
          b.wstrb[(int'(a) + i) % 4] = 1'b1;
        end
      if (!ld) for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = d[8*(i%sz) +: 8];
      if (ld && !f3[2] && sz < 4 && val[8*sz-1]) val |= ~((32'd1 << (8*sz)) - 1);
      exp_bus.push_back(b);
      exp_done.push_back(val);
    end
    lsu_valid_i = v; is_load_i = ld; is_store_i = st; flush_i = fl;
    funct3_i = f3; addr_i = a; wdata_i = d;
    issue_cyc = cyc;
    #1 chk("stall_issue", 72'(stall_o), 72'(ok));
    @(posedge clk); #1;
    lsu_valid_i = 0; flush_i = 0;
    {is_load_i, is_store_i} = 2'($urandom);
    funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
    #1 chk("stall_busy", 72'(stall_o), 72'(ok));
    for (int n = 0; n < 60 && (exp_bus.size() + exp_done.size() + exp_err.size()) > 0; n++) begin
      @(posedge clk); #1;
    end
    if ((exp_bus.size() + exp_done.size() + exp_err.size()) > 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: %0d events still pending, required 0", exp_bus.size() + exp_done.size() + exp_err.size());
      exp_bus.delete(); exp_done.delete(); exp_err.delete();
    end
  endtask
  task automatic drive_lw(logic [31:0] a);
    lsu_valid_i = 1; is_load_i = 1; is_store_i = 0; flush_i = 0; funct3_i = 3'd2; addr_i = a;
  endtask
  initial begin
    bus_t b;
    int cnt0;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", 72'({mem.req, mem.we, mem.addr, mem.wstrb, stall_o, done_o, err_o, err_cause_o}), 72'(0));
    chk("reset_data", 72'({load_data_o, err_addr_o}), 72'(0));
    rst_n = 1;
    @(posedge clk); #1;
    gdelay = 0; rmin = 0; rmax = 0;
    issue(1, 0, 1, 0, 3'd2, 32'h100, 32'hDEADBEEF);
    chk("sw_gnt_cycle", 72'(last_gnt_cyc - issue_cyc), 72'(1));
    chk("sw_done_cycle", 72'(last_done_cyc - issue_cyc), 72'(2));
    gdelay = 3;
    issue(1, 0, 1, 0, 3'd0, 32'h103, 32'h000000A5);
    chk("sb_gnt_delay", 72'(last_gnt_cyc - issue_cyc), 72'(4));
    chk("sb_done_after_gnt", 72'(last_done_cyc - last_gnt_cyc), 72'(1));
    gdelay = 0;
    issue(1, 0, 1, 0, 3'd2, 32'h200, 32'h0080FF00);
    issue(1, 1, 0, 0, 3'd0, 32'h202, 32'h0);
    chk("lb_value", 72'(last_load), 72'(32'hFFFFFF80));
    chk("load_latency", 72'(last_done_cyc - issue_cyc), 72'(3));
    issue(1, 1, 0, 0, 3'd4, 32'h202, 32'h0);
    chk("lbu_value", 72'(last_load), 72'(32'h00000080));
    issue(1, 0, 1, 0, 3'd2, 32'h200, 32'h80011234);
    issue(1, 1, 0, 0, 3'd5, 32'h202, 32'h0);
    chk("lhu_value", 72'(last_load), 72'(32'h00008001));
    issue(1, 1, 0, 0, 3'd2, 32'h105, 32'h0);
    chk("err_lw_mis", 72'({last_cause, last_eaddr}), 72'({2'b01, 32'h105}));
    issue(1, 0, 1, 0, 3'd1, 32'h301, 32'h0);
    chk("err_sh_mis", 72'({last_cause, last_eaddr}), 72'({2'b10, 32'h301}));
    issue(1, 1, 0, 0, 3'd3, 32'h400, 32'h0);
    chk("err_width", 72'({last_cause, last_eaddr}), 72'({2'b11, 32'h400}));
    // flush while the request is still waiting for its grant
    gnt_off = 1;
    cnt0 = done_cnt;
    drive_lw(32'h208);
    @(posedge clk); #1 lsu_valid_i = 0;
    chk("fl_req_up", 72'(mem.req), 72'(1));
    @(posedge clk); #1 flush_i = 1;
    chk("fl_req_held", 72'(mem.req), 72'(1));
    @(posedge clk); #1 flush_i = 0;
    chk("fl_req_drop", 72'({mem.req, stall_o}), 72'(0));
    gnt_off = 0;
    repeat (3) @(posedge clk);
    #1 chk("fl_no_done", 72'(done_cnt), 72'(cnt0));
    // flush after the grant: rvalid still consumed, done suppressed
    rmin = 2; rmax = 2;
    b = '0;
    b.addr = 32'h20C;
    exp_bus.push_back(b);
    cnt0 = done_cnt;
    drive_lw(32'h20C);
    @(posedge clk); #1 lsu_valid_i = 0;
    @(posedge clk); #1 flush_i = 1;
    chk("flg_stall_rsp", 72'(stall_o), 72'(1));
    @(posedge clk); #1 flush_i = 0;
    chk("flg_stall_wait", 72'(stall_o), 72'(1));
    @(posedge clk); #1 chk("flg_stall_rvalid", 72'(stall_o), 72'(1));
    @(posedge clk); #1 chk("flg_stall_idle", 72'(stall_o), 72'(0));
    repeat (2) @(posedge clk);
    #1 chk("flg_no_done", 72'(done_cnt), 72'(cnt0));
    chk("flg_granted", 72'(exp_bus.size()), 72'(0));
    // reset while waiting for read data
    rmin = 3; rmax = 3;
    b.addr = 32'h210;
    exp_bus.push_back(b);
    cnt0 = done_cnt;
    drive_lw(32'h210);
    @(posedge clk); #1 lsu_valid_i = 0;
    @(posedge clk); #1 chk("rst_in_rsp", 72'(stall_o), 72'(1));
    rst_n = 0;
    #1 chk("rst_async_outs", 72'({mem.req, stall_o, done_o, err_o, load_data_o}), 72'(0));
    @(posedge clk); #1 rst_n = 1;
    for (int n = 0; n < 10 && pend; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 chk("rst_no_done", 72'(done_cnt), 72'(cnt0));
    gdelay = -1; rmin = 0; rmax = 2;
    issue(1, 1, 0, 0, 3'd2, 32'h200, 32'h0);
    chk("lw_after_rst", 72'(last_load), 72'(32'h80011234));
    for (int k = 0; k < 250; k++) begin
      int sel;
      bit ld, st;
      sel = int'($urandom_range(9, 0));
      ld = sel == 1 || (sel > 1 && $urandom_range(1, 0) == 1);
      st = sel == 1 || (sel > 1 && !ld);
      issue($urandom_range(15, 0) != 0, ld, st, $urandom_range(15, 0) == 0,
            3'($urandom), 32'h200 + $urandom_range(31, 0), $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
